// File: rtl/seqmul_if.sv
// seqmul_if: start/done handshake and operand/product bus for the sequential
// shift-add multiplier. The requester drives operands and the start strobe;
// the multiplier returns the product register and its status flags.
interface seqmul_if #(
  parameter int WIDTH = 19
);
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic               sample;
  logic [2*WIDTH-1:0] P_out;
  logic               busy;
  logic               done;

  modport master (
    output mcand,
    output mplier,
    output sample,
    input  P_out,
    input  busy,
    input  done
  );

  modport slave (
    input  mcand,
    input  mplier,
    input  sample,
    output P_out,
    output busy,
    output done
  );
endinterface

// File: rtl/seqmul.sv
// seqmul: sequential unsigned shift-add multiplier.
// An accepted start loads {0, mplier} into the accumulator. Each RUN cycle
// conditionally adds the multiplicand into the upper half, keeping the carry,
// and shifts right by one. After exactly WIDTH iterations the full 2*WIDTH
// product is copied into P_out. There is no early exit on zero operands, so
// latency is always WIDTH cycles after the accepting edge.
module seqmul #(
  parameter int WIDTH = 19
) (
  input  logic     clk,
  input  logic     nRST,
  seqmul_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [WIDTH-1:0]   mc_r, mc_s;
  logic [2*WIDTH-1:0] acc_r, acc_s;
  logic [CW-1:0]      cnt_r, cnt_s;
  logic [2*WIDTH-1:0] p_r, p_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic [WIDTH:0]     sum_s;

  // State, datapath and output registers; cleared asynchronously by nRST.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_r <= IDLE;
      mc_r    <= {WIDTH{1'b0}};
      acc_r   <= {(2*WIDTH){1'b0}};
      cnt_r   <= {CW{1'b0}};
      p_r     <= {(2*WIDTH){1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      mc_r    <= mc_s;
      acc_r   <= acc_s;
      cnt_r   <= cnt_s;
      p_r     <= p_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  // Next-state, one shift-add iteration and next values of the registered flags.
  always_comb begin
    state_s = state_r;
    mc_s    = mc_r;
    acc_s   = acc_r;
    cnt_s   = cnt_r;
    p_s     = p_r;
    busy_s  = busy_r;
    done_s  = done_r;
    // Partial add is WIDTH+1 bits wide so the carry survives the shift.
    sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, mc_r};

    case (state_r)
      IDLE, DONE: begin
        if (bus.sample) begin
          mc_s    = bus.mcand;
          acc_s   = {{WIDTH{1'b0}}, bus.mplier};
          cnt_s   = CW'(WIDTH);
          state_s = RUN;
          busy_s  = 1'b1;
          done_s  = 1'b0;
        end else begin
          state_s = state_r;
          busy_s  = 1'b0;
          done_s  = (state_r == DONE);
        end
      end
      RUN: begin
        if (acc_r[0]) begin
          acc_s = {sum_s, acc_r[WIDTH-1:1]};
        end else begin
          acc_s = {1'b0, acc_r[2*WIDTH-1:1]};
        end
        cnt_s = cnt_r - CW'(1);
        if (cnt_r == CW'(1)) begin
          p_s     = acc_s;
          state_s = DONE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
        end else begin
          state_s = RUN;
          busy_s  = 1'b1;
          done_s  = 1'b0;
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
        done_s  = 1'b0;
      end
    endcase
  end

  assign bus.P_out = p_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;

endmodule

// File: tb/tb_seqmul.sv
// tb_seqmul: scoreboard bench for the sequential multiplier. Expected products
// are pushed when a start is driven and popped when done rises.
module tb_seqmul;

  localparam int W = 19;
  typedef logic [2*W-1:0] prod_t;

  logic clk;
  logic nRST;
  int   n_checks;
  int   n_fails;
  prod_t exp_q[$];
  prod_t last_p;

  seqmul_if #(.WIDTH(W)) bus ();

  seqmul #(.WIDTH(W)) dut (
    .clk  (clk),
    .nRST (nRST),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive a start for one cycle; returns just after the accepting edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.mcand  = a;
    bus.mplier = b;
    bus.sample = 1'b1;
    exp_q.push_back(prod_t'(a) * prod_t'(b));
    @(posedge clk); #1;
    bus.sample = 1'b0;
    bus.mcand  = W'($urandom);
    bus.mplier = W'($urandom);
    check("accept_busy", 64'(bus.busy), 64'(1));
    check("accept_done", 64'(bus.done), 64'(0));
  endtask

  // Wait for done, checking RUN flags and P_out hold; optional strobe at cycle strobe_at.
  task automatic wait_done(input int strobe_at, input logic [W-1:0] sa, input logic [W-1:0] sb);
    int n;
    prod_t e;
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      bus.sample = 1'b0;
      if (bus.done) break;
      check("run_busy", 64'(bus.busy), 64'(1));
      check("run_hold", 64'(bus.P_out), 64'(last_p));
      if (n == strobe_at) begin
        bus.mcand  = sa;
        bus.mplier = sb;
        bus.sample = 1'b1;
      end
    end
    check("latency", 64'(n), 64'(W));
    check("done_busy", 64'(bus.busy), 64'(0));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("product", 64'(bus.P_out), 64'(e));
      last_p = e;
    end else begin
      check("sb_empty", 64'(exp_q.size()), 64'(1));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic prev_done;
    logic exp_done;
    prod_t e;
    n_checks   = 0;
    n_fails    = 0;
    last_p     = '0;
    nRST       = 1'b0;
    bus.sample = 1'b0;
    bus.mcand  = '0;
    bus.mplier = '0;
    #12;
    check("rst_p", 64'(bus.P_out), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    nRST = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", 64'(bus.busy), 64'(0));

    // Basic product; P_out must stay 0 during RUN.
    start_op(19'd137260, 19'd152890);
    wait_done(0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    check("done_stays", 64'(bus.done), 64'(1));
    check("done_p_hold", 64'(bus.P_out), 64'(last_p));

    // All ones: carry out of every partial add.
    start_op(19'd524287, 19'd524287);
    wait_done(0, '0, '0);

    // Zero operands still take full latency.
    start_op(19'd0, 19'd524287);
    wait_done(0, '0, '0);
    start_op(19'd12345, 19'd0);
    wait_done(0, '0, '0);

    // Strobe during RUN ignored; strobe in DONE accepted.
    start_op(19'd3, 19'd5);
    wait_done(6, 19'd7, 19'd9);
    start_op(19'd7, 19'd9);
    wait_done(0, '0, '0);

    // Asynchronous reset mid-RUN.
    start_op(19'd1000, 19'd1000);
    repeat (10) @(posedge clk);
    #3;
    nRST = 1'b0;
    #1;
    check("arst_busy", 64'(bus.busy), 64'(0));
    check("arst_done", 64'(bus.done), 64'(0));
    check("arst_p", 64'(bus.P_out), 64'(0));
    void'(exp_q.pop_back());
    last_p = '0;
    #9;
    nRST = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      check("post_rst_busy", 64'(bus.busy), 64'(0));
      check("post_rst_done", 64'(bus.done), 64'(0));
      check("post_rst_p", 64'(bus.P_out), 64'(0));
    end

    // sample held high: back-to-back operations, done pulses for one cycle.
    bus.mcand  = 19'd2;
    bus.mplier = 19'd3;
    bus.sample = 1'b1;
    prev_done  = 1'b0;
    for (int k = 1; k <= 62; k++) begin
      @(posedge clk); #1;
      r = k - 1;
      if ((r % 20 == 0) && (r < 50)) exp_q.push_back(prod_t'(6));
      exp_done = (r % 20 == 19) || (r >= 59);
      check("hold_done", 64'(bus.done), 64'(exp_done));
      check("hold_busy", 64'(bus.busy), 64'(!exp_done));
      if (bus.done && !prev_done) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("hold_product", 64'(bus.P_out), 64'(e));
        end else begin
          check("hold_sb_empty", 64'(exp_q.size()), 64'(1));
        end
      end
      prev_done = bus.done;
      if (k == 50) bus.sample = 1'b0;
    end
    check("sb_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
